uart_tx_buffer: RTL and testbench

Transmit-side byte buffer that sits directly upstream of the UART transmitter and feeds its `uart_wr_i`/`uart_dat_i` inputs. It accepts bytes from the core's memory-mapped store path into a DEPTH-entry FIFO. It issues them to the transmitter as single-cycle write pulses spaced by a fixed frame interval. The transmitter exports no busy signal, so pacing is entirely this block's responsibility.

---
 rtl/uart_tx_buffer_if.sv | 26 ++
 rtl/uart_tx_buffer.sv | 109 ++++++++++
 tb/tb_uart_tx_buffer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffer_if.sv
// rtl/uart_tx_buffer_if.sv - store-path and transmitter-side signals of the UART transmit buffer
interface uart_tx_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr_en_i;
  logic [7:0]    wr_data_i;
  logic          clr_ovf_i;
  logic          full_o;
  logic          empty_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic          uart_wr_o;
  logic [7:0]    uart_dat_o;

  modport slave (
    input  wr_en_i, wr_data_i, clr_ovf_i,
    output full_o, empty_o, level_o, overflow_o, uart_wr_o, uart_dat_o
  );

  modport master (
    output wr_en_i, wr_data_i, clr_ovf_i,
    input  full_o, empty_o, level_o, overflow_o, uart_wr_o, uart_dat_o
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - byte FIFO that paces single-cycle writes into a UART transmitter
module uart_tx_buffer #(
  parameter int DEPTH           = 16,
  parameter int CYCLES_PER_BYTE = 10417
) (
  input  logic             sys_clk_i,
  input  logic             sys_rstn_i,
  uart_tx_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CYCLES_PER_BYTE);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [CW-1:0] GAP_LOAD = CW'(CYCLES_PER_BYTE - 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_nxt;
  logic [CW-1:0] gap;
  state_t        state;
  logic          full_q;
  logic          empty_q;
  logic          ovf_q;
  logic          uart_wr_q;
  logic [7:0]    uart_dat_q;
  logic          push;
  logic          pop;

  // Acceptance looks only at the registered level, so a same-cycle pop never rescues a push.
  always_comb begin
    push      = bus.wr_en_i && (level < DEPTH_L);
    pop       = (level != '0) && ((state == S_IDLE) || ((state == S_WAIT) && (gap == '0)));
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + 1'b1;
    end else if (pop && !push) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data_i;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      gap        <= '0;
      state      <= S_IDLE;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= 8'h00;
    end else begin
      level   <= level_nxt;
      full_q  <= (level_nxt == DEPTH_L);
      empty_q <= (level_nxt == '0);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (bus.wr_en_i && !push) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf_i) begin
        ovf_q <= 1'b0;
      end
      // Every pop is exactly the transition into ISSUE, so the strobe is the registered pop.
      uart_wr_q <= pop;
      if (pop) begin
        uart_dat_q <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          gap   <= GAP_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (gap == '0) begin
            state <= pop ? S_ISSUE : S_IDLE;
          end else begin
            gap <= gap - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.full_o     = full_q;
  assign bus.empty_o    = empty_q;
  assign bus.level_o    = level;
  assign bus.overflow_o = ovf_q;
  assign bus.uart_wr_o  = uart_wr_q;
  assign bus.uart_dat_o = uart_dat_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - directed self-checking bench for uart_tx_buffer
module tb_uart_tx_buffer;
  localparam int DEPTH = 4;
  localparam int CPB   = 20;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_dat;
    int         exp_gap;
  } vec_t;

  logic sys_clk_i = 1'b0;
  logic sys_rstn_i;
  int   tests   = 0;
  int   failed  = 0;
  int   cyc     = 0;
  int   max_lvl = 0;
  logic prev_wr = 1'b0;
  logic [7:0] sdat[$];
  int         stime[$];
  vec_t       vecs[12];

  always #5 sys_clk_i = ~sys_clk_i;

  uart_tx_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_buffer #(.DEPTH(DEPTH), .CYCLES_PER_BYTE(CPB)) dut (
    .sys_clk_i  (sys_clk_i),
    .sys_rstn_i (sys_rstn_i),
    .bus        (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge sys_clk_i) cyc <= cyc + 1;

  always @(negedge sys_clk_i) begin
    if (bus.uart_wr_o === 1'b1) begin
      check("strobe_single_cycle", {31'd0, prev_wr}, 32'd0);
      sdat.push_back(bus.uart_dat_o);
      stime.push_back(cyc);
    end
    prev_wr = bus.uart_wr_o;
    if (int'(bus.level_o) > max_lvl) max_lvl = int'(bus.level_o);
  end

  task automatic do_reset();
    sys_rstn_i = 1'b0;
    repeat (2) @(negedge sys_clk_i);
    sys_rstn_i = 1'b1;
    sdat.delete();
    stime.delete();
  endtask

  // Push accepted at the next rising edge; returns that edge's index.
  task automatic push_byte(input logic [7:0] d, output int edge_k);
    @(negedge sys_clk_i);
    bus.wr_en_i   = 1'b1;
    bus.wr_data_i = d;
    @(posedge sys_clk_i);
    #1;
    edge_k = cyc;
    bus.wr_en_i = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (sdat.size() < n && k < budget) begin
      @(negedge sys_clk_i);
      #1;
      k++;
    end
    if (sdat.size() < n) check("strobe_timeout", sdat.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int e;
    int nff;
    bus.wr_en_i   = 1'b0;
    bus.wr_data_i = 8'h00;
    bus.clr_ovf_i = 1'b0;
    sys_rstn_i    = 1'b0;

    for (int i = 0; i < 12; i++) begin
      vecs[i].din     = 8'h40 + 8'(i * 7);
      vecs[i].exp_dat = 8'h40 + 8'(i * 7);
      vecs[i].exp_gap = (i == 0) ? 1 : CPB;
    end

    // 1: reset values and single-byte latency
    do_reset();
    #1;
    check("rst_level", 32'(bus.level_o), 0);
    check("rst_empty", 32'(bus.empty_o), 1);
    check("rst_full", 32'(bus.full_o), 0);
    check("rst_ovf", 32'(bus.overflow_o), 0);
    check("rst_uart_wr", 32'(bus.uart_wr_o), 0);
    check("rst_uart_dat", 32'(bus.uart_dat_o), 0);
    push_byte(8'hA5, k);
    wait_strobes(1, 50);
    if (sdat.size() >= 1) begin
      check("s1_latency", stime[0] - k, 1);
      check("s1_data", 32'(sdat[0]), 32'hA5);
    end
    repeat (100) @(negedge sys_clk_i);
    check("s1_no_more_strobes", sdat.size(), 1);
    check("s1_empty", 32'(bus.empty_o), 1);

    // 2: fill while issuer is busy, ordered strobes spaced exactly CPB
    do_reset();
    push_byte(8'h00, k);
    wait_strobes(1, 50);
    for (int i = 1; i <= 4; i++) push_byte(8'(i), k);
    check("s2_full", 32'(bus.full_o), 1);
    check("s2_level", 32'(bus.level_o), 4);
    wait_strobes(5, 200);
    if (sdat.size() >= 5) begin
      for (int i = 1; i <= 4; i++) begin
        check("s2_order", 32'(sdat[i]), i);
        check("s2_spacing", stime[i] - stime[i-1], CPB);
      end
    end
    check("s2_empty_after_pops", 32'(bus.empty_o), 1);

    // 3: overflow drop, clear, and set-beats-clear
    do_reset();
    push_byte(8'h10, k);
    wait_strobes(1, 50);
    for (int i = 1; i <= 4; i++) push_byte(8'h10 + 8'(i), k);
    push_byte(8'hFF, k);
    check("s3_ovf_set", 32'(bus.overflow_o), 1);
    check("s3_level_unchanged", 32'(bus.level_o), 4);
    @(negedge sys_clk_i);
    bus.clr_ovf_i = 1'b1;
    @(posedge sys_clk_i);
    #1;
    bus.clr_ovf_i = 1'b0;
    check("s3_ovf_cleared", 32'(bus.overflow_o), 0);
    @(negedge sys_clk_i);
    bus.clr_ovf_i = 1'b1;
    bus.wr_en_i   = 1'b1;
    bus.wr_data_i = 8'hFF;
    @(posedge sys_clk_i);
    #1;
    bus.clr_ovf_i = 1'b0;
    bus.wr_en_i   = 1'b0;
    check("s3_set_beats_clr", 32'(bus.overflow_o), 1);
    wait_strobes(5, 300);
    repeat (100) @(negedge sys_clk_i);
    check("s3_strobe_count", sdat.size(), 5);
    nff = 0;
    foreach (sdat[i]) if (sdat[i] == 8'hFF) nff++;
    check("s3_ff_never_issued", nff, 0);
    if (sdat.size() >= 5)
      for (int i = 0; i < 5; i++) check("s3_order", 32'(sdat[i]), 32'h10 + i);

    // 4: table-driven push at the pop rate across pointer wrap-arounds
    do_reset();
    max_lvl = 0;
    for (int i = 0; i < 12; i++) begin
      push_byte(vecs[i].din, k);
      wait_strobes(i + 1, 60);
      if (sdat.size() >= i + 1) begin
        check("s4_data", 32'(sdat[i]), 32'(vecs[i].exp_dat));
        if (i == 0) check("s4_first_latency", stime[0] - k, vecs[i].exp_gap);
        else        check("s4_gap", stime[i] - stime[i-1], vecs[i].exp_gap);
      end
    end
    check("s4_no_overflow", 32'(bus.overflow_o), 0);
    check("s4_level_bound", 32'(max_lvl <= DEPTH), 1);

    // 5: asynchronous reset mid-WAIT with bytes queued
    do_reset();
    push_byte(8'h20, k);
    wait_strobes(1, 50);
    for (int i = 1; i <= 3; i++) push_byte(8'h20 + 8'(i), k);
    check("s5_queued", 32'(bus.level_o), 3);
    @(posedge sys_clk_i);
    #2;
    sys_rstn_i = 1'b0;
    #1;
    check("s5_async_uart_wr", 32'(bus.uart_wr_o), 0);
    check("s5_async_uart_dat", 32'(bus.uart_dat_o), 0);
    check("s5_async_level", 32'(bus.level_o), 0);
    check("s5_async_empty", 32'(bus.empty_o), 1);
    check("s5_async_full", 32'(bus.full_o), 0);
    @(negedge sys_clk_i);
    sys_rstn_i = 1'b1;
    sdat.delete();
    stime.delete();
    push_byte(8'h3C, k);
    wait_strobes(1, 50);
    if (sdat.size() >= 1) begin
      check("s5_latency", stime[0] - k, 1);
      check("s5_data", 32'(sdat[0]), 32'h3C);
    end
    repeat (60) @(negedge sys_clk_i);
    check("s5_queue_flushed", sdat.size(), 1);

    // 6: push landing on the final WAIT edge takes the IDLE detour
    do_reset();
    push_byte(8'hB1, k);
    wait_strobes(1, 50);
    e = (stime.size() >= 1) ? stime[0] : cyc;
    k = 0;
    while (cyc < e + CPB - 1 && k < 100) begin
      @(negedge sys_clk_i);
      k++;
    end
    bus.wr_en_i   = 1'b1;
    bus.wr_data_i = 8'hB2;
    @(posedge sys_clk_i);
    #1;
    bus.wr_en_i = 1'b0;
    wait_strobes(2, 60);
    if (sdat.size() >= 2) begin
      check("s6_late_gap", stime[1] - stime[0], CPB + 1);
      check("s6_data", 32'(sdat[1]), 32'hB2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
